rf_hazard_scoreboard: RTL
=========================

Name: rf_hazard_scoreboard

Overview:
- Decode-stage scheduler for the in-order pipeline.
- Tracks pending register-file writes from issued instructions using a per-register countdown scoreboard.
- Drives ST into the control unit so it emits a bubble (all controls 0), and freezes PC and the IF/ID register until every source operand has been written back.
- Also honours a global pipeline hold and keeps a stall-cycle performance counter.

Parameters:
- REG_AW, 3, register address width; NUM_REGS = 2**REG_AW.
- WB_LAT, 2, stall cycles a back-to-back dependent instruction must wait; legal range 1..7.
- CNT_W, 3, scoreboard counter width; must satisfy 2**CNT_W > WB_LAT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  instruction present in ID.
- Opcode  in  4  ID-stage opcode.
- Rs  in  REG_AW  source 1 field.
- Rt  in  REG_AW  source 2 / ADDI destination field.
- Rd  in  REG_AW  R-type destination field.
- ext_hold  in  1  global pipeline freeze request.
- ST  out  1  stall/bubble to control unit.
- PC_En  out  1  PC write enable.
- IFID_En  out  1  IF/ID register write enable.
- Busy  out  NUM_REGS  bit i = register i has a pending write.
- StallCnt  out  16  saturating count of stall cycles.

Behaviour:
- Opcode decode (combinational):
  - SW 0000: reads Rs and Rt; no write.
  - NOR 0001, AND 0111, OR 1111: read Rs and Rt; write Rd.
  - ADDI 0011: reads Rs; writes Rt.
  - Any other opcode: NOP; no reads, no write, never stalls.
- All registers, including register 0, are tracked identically.
- State: cnt[i] (CNT_W bits) per register. Busy[i] = (cnt[i] != 0).
- hazard = id_valid AND ((reads Rs AND Busy[Rs]) OR (reads Rt AND Busy[Rt])).
- Outputs (combinational):
  - ST = rst OR ext_hold OR hazard.
  - PC_En = IFID_En = NOT ST.
- issue = id_valid AND NOT ST.
- Per-edge update of cnt[i]:
  - rst: cnt[i] <= 0 and StallCnt <= 0. This applies mid-stall too; pending writes are forgotten.
  - else if ext_hold: all cnt[i] hold their value (the whole pipeline is frozen).
  - else if issue and instruction writes register i: cnt[i] <= WB_LAT. This takes priority over decrement on the same register.
  - else if cnt[i] != 0: cnt[i] <= cnt[i] - 1. This includes hazard-stall cycles, since bubbles advance downstream.
- Dependency timing: an instruction issued at edge t makes a dependent instruction immediately behind it stall for exactly WB_LAT cycles; the dependent issues on the next cycle.
- A dependent with k independent instructions between it and its producer stalls max(0, WB_LAT - k) cycles.
- Self-dependency (e.g. NOR R1,R1,R2 with R1 idle) does not stall; it then loads cnt[1].
- A stalled instruction never loads the scoreboard. Re-presenting the same instruction each cycle is expected.
- id_valid = 0: no hazard, no issue; counters still decrement.
- StallCnt increments by 1 on each edge where ST = 1 and rst = 0. It saturates at 0xFFFF with no wrap.
- Reset values:
  - during rst: ST = 1, PC_En = 0, IFID_En = 0.
  - after rst: Busy = 0, StallCnt = 0.
- Latency: ST/enables respond combinationally in the same cycle. Scoreboard effects are visible in the cycle after issue.

Test Plan:
1. Reset: rst = 1 for 2 cycles -> ST = 1, PC_En = 0, Busy = 0, StallCnt = 0. After release with id_valid = 0 -> ST = 0, PC_En = 1.
2. Back-to-back RAW: ADDI R2 <- R1, then NOR R3,R2,R4 (WB_LAT = 2) -> ST = 1 for exactly 2 cycles, NOR issues on the 3rd, Busy[3] set next cycle, StallCnt = 2.
3. Independent stream: AND R5,R1,R2 then OR R6,R3,R4 then SW Rs = R0, Rt = R7 -> ST never asserts, Busy = 8'b0110_0000 after the OR.
4. Distance 1: ADDI R4, then independent AND, then SW with Rt = R4 -> exactly 1 stall cycle. SW reading only Rs = R4 produces the same result.
5. ext_hold: with cnt[2] = 2, hold for 3 cycles -> ST = 1 throughout, Busy[2] stays 1, StallCnt += 3. After release, a dependent on R2 stalls 2 more cycles.
6. Opcode 0101 with Rs = Rt = Rd = R2 while R2 busy -> no stall, and Busy[2] follows its own countdown only. Assert rst mid-stall -> all Busy clear the next cycle, and the stalled instruction issues once rst drops.

Source files
------------

// File: rtl/rf_hazard_scoreboard.sv
// Decode-stage RAW hazard scheduler: per-register countdown scoreboard that
// stalls ID (bubble + PC/IF-ID freeze) until source operands are written back.
module rf_hazard_scoreboard #(
  parameter int REG_AW = 3,
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [3:0]               Opcode,
  input  logic [REG_AW-1:0]        Rs,
  input  logic [REG_AW-1:0]        Rt,
  input  logic [REG_AW-1:0]        Rd,
  input  logic                     ext_hold,
  output logic                     ST,
  output logic                     PC_En,
  output logic                     IFID_En,
  output logic [(2**REG_AW)-1:0]   Busy,
  output logic [15:0]              StallCnt
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

  // Handshake: ID holds an instruction while id_valid=1; it is consumed
  // (issued) on a rising edge where id_valid=1 and ST=0, otherwise it must
  // be re-presented unchanged on the following cycle.

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [15:0]       stall_cnt_q;
  logic              reads_rs;
  logic              reads_rt;
  logic              writes;
  logic [REG_AW-1:0] wr_addr;
  logic              hazard;
  logic              issue;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    wr_addr  = Rd;
    unique case (Opcode)
      4'b0000: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      4'b0001, 4'b0111, 4'b1111: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
      end
      4'b0011: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        wr_addr  = Rt;
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      Busy[i] = (cnt_q[i] != '0);
    end
  end

  assign hazard   = id_valid & ((reads_rs & Busy[Rs]) | (reads_rt & Busy[Rt]));
  assign ST       = rst | ext_hold | hazard;
  assign PC_En    = ~ST;
  assign IFID_En  = ~ST;
  assign issue    = id_valid & ~ST;
  assign StallCnt = stall_cnt_q;

  // A fresh load wins over the countdown; hazard bubbles still count down
  // because the producer keeps moving toward writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (!ext_hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue && writes && (wr_addr == REG_AW'(i))) begin
          cnt_q[i] <= LAT;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (ST && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
